comp_page_dispatcher: RTL

// Front end of the compression datapath: accepts the host page stream (AXI_DATA_BITS wide) and

---
 rtl/comp_page_dispatcher_if.sv | 43 ++++
 rtl/comp_page_dispatcher.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/comp_page_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : comp_page_dispatcher_if
// Purpose  : Bus bundle for comp_page_dispatcher. It carries the host page
//            stream (s_axis_*) and the per-core word streams (m_axis_*).
//            master = host/core side (drives the page stream and core readies)
//            slave  = dispatcher side
// Signals  : s_axis_tdata  [DATA_BITS]          page data beat
//            s_axis_tvalid / s_axis_tlast       beat valid / host end-of-page
//            s_axis_tready                      beat accepted when valid&&ready
//            m_axis_tdata  [N_CORES*CORE_BITS]  lane i = [i*CORE_BITS +: CORE_BITS]
//            m_axis_tvalid/tlast/tready [N_CORES] per-core handshake
// Revision : 1.0  initial release
// ============================================================================
interface comp_page_dispatcher_if #(
  parameter int DATA_BITS = 512,
  parameter int CORE_BITS = 64,
  parameter int N_CORES   = 4
);
  logic [DATA_BITS-1:0]         s_axis_tdata;
  logic                         s_axis_tvalid;
  logic                         s_axis_tlast;
  logic                         s_axis_tready;
  logic [N_CORES*CORE_BITS-1:0] m_axis_tdata;
  logic [N_CORES-1:0]           m_axis_tvalid;
  logic [N_CORES-1:0]           m_axis_tlast;
  logic [N_CORES-1:0]           m_axis_tready;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );
endinterface
`default_nettype wire

// File: rtl/comp_page_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : comp_page_dispatcher
// Purpose  : Accepts the host page stream and hands whole pages to N_CORES
//            compressor cores in strict round-robin order, serialising each
//            DATA_BITS beat into WORDS words of CORE_BITS for the owning core.
//            Page n always lands on core n mod N_CORES.
// Ports    : aclk        clock
//            aresetn     synchronous reset, active-low
//            bus         comp_page_dispatcher_if.slave (s_axis_* in, m_axis_* out)
//            core_sel    core receiving the current page
//            pages_done  pages fully dispatched (wraps at 2^32)
//            err_tlast   sticky: host tlast disagreed with page framing
// Revision : 1.0  initial release
// ============================================================================
module comp_page_dispatcher #(
  parameter int DATA_BITS  = 512,
  parameter int CORE_BITS  = 64,
  parameter int N_CORES    = 4,
  parameter int PAGE_BYTES = 8192,
  localparam int SEL_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  wire logic             aclk,
  input  wire logic             aresetn,
  comp_page_dispatcher_if.slave bus,
  output logic [SEL_W-1:0]      core_sel,
  output logic [31:0]           pages_done,
  output logic                  err_tlast
);

  localparam int WORDS      = DATA_BITS / CORE_BITS;
  localparam int PAGE_BEATS = PAGE_BYTES * 8 / DATA_BITS;
  localparam int WIDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BEAT_W     = (PAGE_BEATS > 1) ? $clog2(PAGE_BEATS) : 1;
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PAGE_BEATS - 1);
  localparam logic [SEL_W-1:0]  LAST_CORE = SEL_W'(N_CORES - 1);

  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_valid;
  logic [WIDX_W-1:0]    r_word_idx;
  logic [BEAT_W-1:0]    r_beat_cnt;   // output-side beat position within page
  logic [BEAT_W-1:0]    r_in_beat;    // input-side beat position, for tlast check
  logic [SEL_W-1:0]     r_core_sel;
  logic [31:0]          r_pages_done;
  logic                 r_err_tlast;

  logic                         w_sel_ready;
  logic                         w_out_hs;
  logic                         w_in_hs;
  logic                         w_last_word;
  logic                         w_page_end;
  logic                         w_s_ready;
  logic [CORE_BITS-1:0]         w_word;
  logic [N_CORES-1:0]           w_m_tvalid;
  logic [N_CORES-1:0]           w_m_tlast;
  logic [N_CORES*CORE_BITS-1:0] w_m_tdata;

  // Ready of the currently selected core; explicit mux keeps non-power-of-2
  // core counts from indexing past the ready vector.
  always_comb begin
    w_sel_ready = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      if (r_core_sel == SEL_W'(i)) begin
        w_sel_ready = bus.m_axis_tready[i];
      end
    end
  end

  // Current word out of the hold register; word 0 is the least significant.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (r_word_idx == WIDX_W'(i)) begin
        w_word = r_hold[i*CORE_BITS +: CORE_BITS];
      end
    end
  end

  assign w_out_hs    = r_hold_valid && w_sel_ready;
  assign w_last_word = (r_word_idx == LAST_WORD);
  assign w_page_end  = w_last_word && (r_beat_cnt == LAST_BEAT);
  // The hold register can take a new beat while its last word is leaving,
  // which keeps one word per cycle flowing across beat boundaries.
  assign w_s_ready   = !r_hold_valid || (w_last_word && w_out_hs);
  assign w_in_hs     = bus.s_axis_tvalid && w_s_ready;

  // Only the selected lane ever shows valid/tlast; data is broadcast.
  always_comb begin
    w_m_tvalid = '0;
    w_m_tlast  = '0;
    w_m_tdata  = '0;
    for (int i = 0; i < N_CORES; i++) begin
      w_m_tdata[i*CORE_BITS +: CORE_BITS] = w_word;
      if (r_core_sel == SEL_W'(i)) begin
        w_m_tvalid[i] = r_hold_valid;
        w_m_tlast[i]  = r_hold_valid && w_page_end;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_word_idx   <= '0;
      r_beat_cnt   <= '0;
      r_in_beat    <= '0;
      r_core_sel   <= '0;
      r_pages_done <= '0;
      r_err_tlast  <= 1'b0;
    end else begin
      if (w_out_hs) begin
        if (w_last_word) begin
          r_word_idx <= '0;
          if (w_page_end) begin
            r_beat_cnt   <= '0;
            r_core_sel   <= (r_core_sel == LAST_CORE) ? '0 : r_core_sel + SEL_W'(1);
            r_pages_done <= r_pages_done + 32'd1;
          end else begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
          end
        end else begin
          r_word_idx <= r_word_idx + WIDX_W'(1);
        end
      end

      if (w_in_hs) begin
        r_hold       <= bus.s_axis_tdata;
        r_hold_valid <= 1'b1;
        r_in_beat    <= (r_in_beat == LAST_BEAT) ? '0 : r_in_beat + BEAT_W'(1);
        // Framing is owned by the beat count; host tlast is only audited.
        if (bus.s_axis_tlast != (r_in_beat == LAST_BEAT)) begin
          r_err_tlast <= 1'b1;
        end
      end else if (w_out_hs && w_last_word) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign bus.s_axis_tready = w_s_ready;
  assign bus.m_axis_tvalid = w_m_tvalid;
  assign bus.m_axis_tlast  = w_m_tlast;
  assign bus.m_axis_tdata  = w_m_tdata;
  assign core_sel          = r_core_sel;
  assign pages_done        = r_pages_done;
  assign err_tlast         = r_err_tlast;

endmodule
`default_nettype wire
